rcpt_range_tlb: RTL and testbench
=================================

# rcpt_range_tlb

Multi-entry, fully associative range TLB for the cRCPT translation path, replacing the single-line range entry. Each entry maps a contiguous virtual page range [SVPN, SVPN_END) onto a contiguous physical run starting at PPN. Lookups are registered with one-cycle latency. The page table walker fills entries using round-robin replacement, with in-place refresh when the same start VPN is already present. Global flush and saturating hit/miss statistics are included.

## Interface
- VPN_WIDTH, 23, virtual page number width
- PPN_WIDTH, VPN_WIDTH, physical page number width
- ATT_WIDTH, 10, attribute width; an entry is accessible only when all ATT bits are 1
- NUM_ENTRIES, 4, number of range entries (power of two, >= 2)
- CNT_WIDTH, 16, statistics counter width
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_lookup  in  1  lookup request strobe
- i_VPN  in  VPN_WIDTH  lookup virtual page number
- o_rspValid  out  1  response valid, one cycle after i_lookup
- o_PPN  out  PPN_WIDTH  translated physical page number
- o_hit  out  1  matched entry with all ATT bits set
- o_fault  out  1  matched entry with any ATT bit clear
- o_miss  out  1  no valid entry matched
- i_ptwUpdate  in  1  fill strobe
- i_ptwVPN  in  VPN_WIDTH  range start, inclusive
- i_ptwVPN_END  in  VPN_WIDTH  range end, exclusive
- i_ptwPPN  in  PPN_WIDTH  physical page number of the range start
- i_ptwATT  in  ATT_WIDTH  attributes
- i_flush  in  1  invalidate all entries
- o_hitCnt  out  CNT_WIDTH  saturating count of hit responses
- o_missCnt  out  CNT_WIDTH  saturating count of miss responses

## Operation
- **Entry state:** SVPN, SVPN_END, PPN, ATT, Val. The replacement pointer rp has log2(NUM_ENTRIES) bits.
- **Match:** entry i matches when Val_i & (i_VPN >= SVPN_i) & (i_VPN < SVPN_END_i). Comparisons are unsigned.
- **Multiple matches:** the lowest index wins. Other matches are ignored.
- **Translation:** PPN = PPN_i + i_VPN − SVPN_i, truncated modulo 2^PPN_WIDTH. The operand is zero-extended or truncated to PPN_WIDTH.
- **Response flags:**
  - Exactly one of hit, fault, miss is 1 when o_rspValid = 1.
  - All flags are 0 when o_rspValid = 0.
  - On miss, o_PPN = 0.
  - When o_rspValid = 0, o_PPN holds 0.
- **Fill, start match:** if any valid entry has SVPN == i_ptwVPN, the lowest such entry is overwritten and rp is unchanged.
- **Fill, otherwise:** entry rp is written, Val is set, and rp ← rp + 1, wrapping at NUM_ENTRIES.
- **Degenerate fill:** an update with i_ptwVPN_END <= i_ptwVPN is dropped. No write occurs and rp is unchanged.
- **Flush:**
  - Clears every Val and sets rp ← 0.
  - Range, PPN and ATT fields keep their contents.
  - i_flush has priority over i_ptwUpdate in the same cycle; the update is discarded.
- **Statistics:**
  - o_hitCnt increments on each response with o_hit.
  - o_missCnt increments on each response with o_miss.
  - Faults are not counted.
  - Both counters saturate at all-ones and are not cleared by flush.

## Timing
- **Reset:**
  - All entry fields are 0 and all Val are 0.
  - rp = 0.
  - o_rspValid, o_PPN, o_hit, o_fault and o_miss are 0.
  - o_hitCnt and o_missCnt are 0.
- **Lookup latency:** i_lookup sampled at edge N produces registered results valid in the cycle after edge N. A lookup is accepted every cycle, with no backpressure.
- **Lookup vs. same-cycle update/flush:** the lookup sees entry state from before that edge. The update or flush becomes visible to lookups sampled at the next edge.
- **Fill latency:** an entry written at edge N can hit on a lookup sampled at edge N+1.
- **Reset mid-operation:** an in-flight response is lost and outputs return to reset values immediately.

## Test plan
- **Reset:** reset, then lookup VPN 0x10 -> one cycle later o_rspValid=1, o_miss=1, o_PPN=0, o_missCnt=1.
- **Hit:**
  - Fill (0x100, 0x108, PPN 0x2000, ATT 0x3FF), then lookup 0x105 -> o_hit=1, o_PPN=0x2005.
  - Lookup 0x108 -> o_miss=1 (exclusive end).
- **Fault:** fill (0x200, 0x210, PPN 0x50, ATT 0x1FF), then lookup 0x200 -> o_fault=1, o_hitCnt and o_missCnt unchanged.
- **Replacement and refresh:**
  - Fill 5 distinct ranges with NUM_ENTRIES=4 -> the first range misses and ranges 2–5 hit.
  - Refill range 3's start VPN with new PPN 0x7000 -> lookups of range 3 return 0x7000-based results, and the next new fill evicts range 2's slot.
- **Simultaneous events:**
  - Lookup 0x105, flush and update asserted in one cycle -> the response is a hit.
  - The following lookup of 0x105 misses.
  - The discarded update's range also misses.
- **Boundaries:**
  - Fill with END=START -> dropped; a lookup in that range misses.
  - Fill (0x7FFFF0, 0x7FFFFF, PPN 0x7FFFFE), then lookup 0x7FFFF3 -> o_PPN=0x000001 (wrap).
  - Force 2^CNT_WIDTH+3 hits -> o_hitCnt=0xFFFF.

Source files
------------

// File: rtl/rcpt_range_tlb.sv
`default_nettype none
// ============================================================================
// Module   : rcpt_range_tlb
// Purpose  : Fully associative range TLB. Each entry maps the virtual page
//            range [svpn, svpn_end) onto a physical run starting at ppn.
//            Lookups are registered with one-cycle latency. Fills use
//            round-robin replacement, with in-place refresh when the start
//            VPN is already resident. Global flush and saturating hit/miss
//            counters are included.
// Ports    : i_clk, i_rst_n (async, active-low)
//            i_lookup, i_VPN -> o_rspValid, o_PPN, o_hit, o_fault, o_miss
//            i_ptwUpdate, i_ptwVPN, i_ptwVPN_END, i_ptwPPN, i_ptwATT (fill)
//            i_flush (invalidate all entries)
//            o_hitCnt, o_missCnt (saturating statistics)
// Revision : 1.0 - initial multi-entry release
// ============================================================================
module rcpt_range_tlb #(
  parameter int VPN_WIDTH   = 23,
  parameter int PPN_WIDTH   = VPN_WIDTH,
  parameter int ATT_WIDTH   = 10,
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lookup,
  input  logic [VPN_WIDTH-1:0] i_VPN,
  output logic                 o_rspValid,
  output logic [PPN_WIDTH-1:0] o_PPN,
  output logic                 o_hit,
  output logic                 o_fault,
  output logic                 o_miss,
  input  logic                 i_ptwUpdate,
  input  logic [VPN_WIDTH-1:0] i_ptwVPN,
  input  logic [VPN_WIDTH-1:0] i_ptwVPN_END,
  input  logic [PPN_WIDTH-1:0] i_ptwPPN,
  input  logic [ATT_WIDTH-1:0] i_ptwATT,
  input  logic                 i_flush,
  output logic [CNT_WIDTH-1:0] o_hitCnt,
  output logic [CNT_WIDTH-1:0] o_missCnt
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  // Translation is done in a width wide enough for both operands, then
  // truncated, so the offset is zero-extended or truncated as needed.
  localparam int SUM_W = (VPN_WIDTH > PPN_WIDTH) ? VPN_WIDTH : PPN_WIDTH;

  logic [VPN_WIDTH-1:0]   svpn     [NUM_ENTRIES];
  logic [VPN_WIDTH-1:0]   svpn_end [NUM_ENTRIES];
  logic [PPN_WIDTH-1:0]   ppn      [NUM_ENTRIES];
  logic [ATT_WIDTH-1:0]   att      [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] val;
  logic [IDX_W-1:0]       rp;

  logic [NUM_ENTRIES-1:0] lk_match;
  logic [NUM_ENTRIES-1:0] st_match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign lk_match[gi] = val[gi] && (i_VPN >= svpn[gi]) && (i_VPN < svpn_end[gi]);
      assign st_match[gi] = val[gi] && (svpn[gi] == i_ptwVPN);
    end
  endgenerate

  // Lowest-index priority encoders: scanning downward leaves the lowest hit.
  logic             lk_any;
  logic [IDX_W-1:0] lk_idx;
  logic             st_any;
  logic [IDX_W-1:0] st_idx;

  always_comb begin
    lk_any = 1'b0;
    lk_idx = '0;
    st_any = 1'b0;
    st_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) begin
        lk_any = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (st_match[i]) begin
        st_any = 1'b1;
        st_idx = IDX_W'(i);
      end
    end
  end

  logic [VPN_WIDTH-1:0] lk_off;
  logic [PPN_WIDTH-1:0] lk_ppn;
  logic                 lk_acc;
  logic                 lk_hit;
  logic                 lk_fault;
  logic                 lk_miss;

  assign lk_off   = i_VPN - svpn[lk_idx];
  assign lk_ppn   = PPN_WIDTH'(SUM_W'(ppn[lk_idx]) + SUM_W'(lk_off));
  assign lk_acc   = &att[lk_idx];
  assign lk_hit   = i_lookup && lk_any && lk_acc;
  assign lk_fault = i_lookup && lk_any && !lk_acc;
  assign lk_miss  = i_lookup && !lk_any;

  // Degenerate ranges are dropped; flush discards a same-cycle update.
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  assign wr_en  = i_ptwUpdate && !i_flush && (i_ptwVPN_END > i_ptwVPN);
  assign wr_idx = st_any ? st_idx : rp;

  // Entry storage and replacement pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        svpn[i]     <= '0;
        svpn_end[i] <= '0;
        ppn[i]      <= '0;
        att[i]      <= '0;
      end
      val <= '0;
      rp  <= '0;
    end else if (i_flush) begin
      val <= '0;
      rp  <= '0;
    end else if (wr_en) begin
      svpn[wr_idx]     <= i_ptwVPN;
      svpn_end[wr_idx] <= i_ptwVPN_END;
      ppn[wr_idx]      <= i_ptwPPN;
      att[wr_idx]      <= i_ptwATT;
      val[wr_idx]      <= 1'b1;
      if (!st_any) begin
        rp <= rp + 1'b1;
      end
    end
  end

  // Registered response; PPN is forced to zero when idle or on a miss.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rspValid <= 1'b0;
      o_PPN      <= '0;
      o_hit      <= 1'b0;
      o_fault    <= 1'b0;
      o_miss     <= 1'b0;
    end else begin
      o_rspValid <= i_lookup;
      o_PPN      <= (i_lookup && lk_any) ? lk_ppn : '0;
      o_hit      <= lk_hit;
      o_fault    <= lk_fault;
      o_miss     <= lk_miss;
    end
  end

  // Saturating statistics, updated together with the response they count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hitCnt  <= '0;
      o_missCnt <= '0;
    end else begin
      if (lk_hit && (o_hitCnt != '1)) begin
        o_hitCnt <= o_hitCnt + 1'b1;
      end
      if (lk_miss && (o_missCnt != '1)) begin
        o_missCnt <= o_missCnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rcpt_range_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcpt_range_tlb
// Purpose  : Scoreboard testbench for rcpt_range_tlb. A behavioural model of
//            the range table predicts each lookup response when the lookup is
//            issued; a monitor pops and compares when the response appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcpt_range_tlb;

  localparam int NE = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_lookup;
  logic [22:0] i_VPN;
  logic        o_rspValid;
  logic [22:0] o_PPN;
  logic        o_hit;
  logic        o_fault;
  logic        o_miss;
  logic        i_ptwUpdate;
  logic [22:0] i_ptwVPN;
  logic [22:0] i_ptwVPN_END;
  logic [22:0] i_ptwPPN;
  logic [9:0]  i_ptwATT;
  logic        i_flush;
  logic [15:0] o_hitCnt;
  logic [15:0] o_missCnt;

  rcpt_range_tlb dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_lookup    (i_lookup),
    .i_VPN       (i_VPN),
    .o_rspValid  (o_rspValid),
    .o_PPN       (o_PPN),
    .o_hit       (o_hit),
    .o_fault     (o_fault),
    .o_miss      (o_miss),
    .i_ptwUpdate (i_ptwUpdate),
    .i_ptwVPN    (i_ptwVPN),
    .i_ptwVPN_END(i_ptwVPN_END),
    .i_ptwPPN    (i_ptwPPN),
    .i_ptwATT    (i_ptwATT),
    .i_flush     (i_flush),
    .o_hitCnt    (o_hitCnt),
    .o_missCnt   (o_missCnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit          hit;
    bit          fault;
    bit          miss;
    logic [22:0] ppn;
    int          hc;
    int          mc;
  } exp_t;

  exp_t        q[$];
  logic [22:0] m_s[NE];
  logic [22:0] m_e[NE];
  logic [22:0] m_p[NE];
  logic [9:0]  m_a[NE];
  bit          m_v[NE];
  int          m_rp;
  int          m_hc;
  int          m_mc;

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_s[i] = '0; m_e[i] = '0; m_p[i] = '0; m_a[i] = '0; m_v[i] = 1'b0;
    end
    m_rp = 0; m_hc = 0; m_mc = 0;
    q.delete();
  endfunction

  function automatic exp_t model_lookup(logic [22:0] vpn);
    exp_t r;
    r.hit = 1'b0; r.fault = 1'b0; r.miss = 1'b1; r.ppn = '0;
    for (int i = 0; i < NE; i++) begin
      if (m_v[i] && vpn >= m_s[i] && vpn < m_e[i]) begin
        r.miss = 1'b0;
        if (m_a[i] == 10'h3FF) begin
          r.hit = 1'b1;
          r.ppn = m_p[i] + (vpn - m_s[i]);
        end else begin
          r.fault = 1'b1;
        end
        break;
      end
    end
    if (r.hit  && m_hc < 65535) m_hc++;
    if (r.miss && m_mc < 65535) m_mc++;
    r.hc = m_hc;
    r.mc = m_mc;
    return r;
  endfunction

  function automatic void model_fill(logic [22:0] s, logic [22:0] e, logic [22:0] p, logic [9:0] a);
    int slot;
    if (e <= s) return;
    slot = -1;
    for (int i = 0; i < NE; i++) begin
      if (m_v[i] && m_s[i] == s) begin
        slot = i;
        break;
      end
    end
    if (slot < 0) begin
      slot = m_rp;
      m_rp = (m_rp + 1) % NE;
    end
    m_s[slot] = s; m_e[slot] = e; m_p[slot] = p; m_a[slot] = a; m_v[slot] = 1'b1;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
    m_rp = 0;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; inputs are sampled at the following posedge and the
  // task returns at the next negedge, when that cycle's response is visible.
  task automatic step(input bit lk, input logic [22:0] vpn, input bit upd,
                      input logic [22:0] s, input logic [22:0] e,
                      input logic [22:0] p, input logic [9:0] a, input bit fl);
    i_lookup = lk; i_VPN = vpn;
    i_ptwUpdate = upd; i_ptwVPN = s; i_ptwVPN_END = e; i_ptwPPN = p; i_ptwATT = a;
    i_flush = fl;
    if (lk) q.push_back(model_lookup(vpn));
    if (fl) model_flush();
    else if (upd) model_fill(s, e, p, a);
    @(negedge i_clk);
    i_lookup = 1'b0; i_ptwUpdate = 1'b0; i_flush = 1'b0;
  endtask

  task automatic lookup(input logic [22:0] vpn);
    step(1'b1, vpn, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic fill(input logic [22:0] s, input logic [22:0] e, input logic [22:0] p, input logic [9:0] a);
    step(1'b0, '0, 1'b1, s, e, p, a, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t ex;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst_n) begin
        if (q.size() > 0) begin
          ex = q.pop_front();
          check("rsp_valid", 64'(o_rspValid), 64'd1);
          check("rsp_hit",   64'(o_hit),   64'(ex.hit));
          check("rsp_fault", 64'(o_fault), 64'(ex.fault));
          check("rsp_miss",  64'(o_miss),  64'(ex.miss));
          if (!ex.fault) check("rsp_ppn", 64'(o_PPN), 64'(ex.ppn));
          check("rsp_hitcnt",  64'(o_hitCnt),  64'(ex.hc));
          check("rsp_misscnt", 64'(o_missCnt), 64'(ex.mc));
        end else begin
          check("idle_valid", 64'(o_rspValid), 64'd0);
          check("idle_flags", 64'({o_hit, o_fault, o_miss}), 64'd0);
          check("idle_ppn",   64'(o_PPN), 64'd0);
          check("idle_hitcnt",  64'(o_hitCnt),  64'(m_hc));
          check("idle_misscnt", 64'(o_missCnt), 64'(m_mc));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hc0, mc0;
    i_rst_n = 1'b0;
    i_lookup = 1'b0; i_VPN = '0;
    i_ptwUpdate = 1'b0; i_ptwVPN = '0; i_ptwVPN_END = '0; i_ptwPPN = '0; i_ptwATT = '0;
    i_flush = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("reset_outs", 64'({o_rspValid, o_hit, o_fault, o_miss}), 64'd0);
    check("reset_ppn",  64'(o_PPN), 64'd0);
    check("reset_cnts", 64'({o_hitCnt, o_missCnt}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // First lookup after reset misses
    lookup(23'h10);
    check("first_valid",   64'(o_rspValid), 64'd1);
    check("first_miss",    64'(o_miss), 64'd1);
    check("first_ppn",     64'(o_PPN), 64'd0);
    check("first_misscnt", 64'(o_missCnt), 64'd1);

    // Hit with translation, and exclusive end
    fill(23'h100, 23'h108, 23'h2000, 10'h3FF);
    lookup(23'h105);
    check("hit_flag", 64'(o_hit), 64'd1);
    check("hit_ppn",  64'(o_PPN), 64'h2005);
    lookup(23'h108);
    check("end_excl_miss", 64'(o_miss), 64'd1);

    // Fault: not counted
    fill(23'h200, 23'h210, 23'h50, 10'h1FF);
    hc0 = int'(o_hitCnt); mc0 = int'(o_missCnt);
    lookup(23'h200);
    check("fault_flag",  64'(o_fault), 64'd1);
    check("fault_cnts",  64'({o_hitCnt, o_missCnt}), 64'({16'(hc0), 16'(mc0)}));

    // Round-robin replacement and in-place refresh
    flush();
    for (int k = 1; k <= 5; k++)
      fill(23'(k * 'h1000), 23'(k * 'h1000 + 'h10), 23'(k * 'h100), 10'h3FF);
    lookup(23'h1001);
    check("evicted_r1_miss", 64'(o_miss), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      lookup(23'(k * 'h1000 + 2));
      check("resident_hit", 64'(o_hit), 64'd1);
    end
    fill(23'h3000, 23'h3010, 23'h7000, 10'h3FF);
    lookup(23'h3004);
    check("refresh_ppn", 64'(o_PPN), 64'h7004);
    fill(23'h6000, 23'h6010, 23'h600, 10'h3FF);
    lookup(23'h2002);
    check("evict_r2_miss", 64'(o_miss), 64'd1);
    lookup(23'h3004);
    check("r3_kept", 64'(o_PPN), 64'h7004);
    lookup(23'h6001);
    check("r6_hit", 64'(o_hit), 64'd1);

    // Same-cycle lookup, flush and update
    flush();
    fill(23'h100, 23'h108, 23'h2000, 10'h3FF);
    step(1'b1, 23'h105, 1'b1, 23'h900, 23'h910, 23'h10, 10'h3FF, 1'b1);
    check("simul_hit", 64'(o_hit), 64'd1);
    lookup(23'h105);
    check("post_flush_miss", 64'(o_miss), 64'd1);
    lookup(23'h905);
    check("discarded_upd_miss", 64'(o_miss), 64'd1);

    // Degenerate fills
    fill(23'h400, 23'h400, 23'h1, 10'h3FF);
    fill(23'h500, 23'h4F0, 23'h1, 10'h3FF);
    lookup(23'h400);
    check("degen_eq_miss", 64'(o_miss), 64'd1);
    lookup(23'h4F8);
    check("degen_lt_miss", 64'(o_miss), 64'd1);

    // PPN wrap
    fill(23'h7FFFF0, 23'h7FFFFF, 23'h7FFFFE, 10'h3FF);
    lookup(23'h7FFFF3);
    check("wrap_ppn", 64'(o_PPN), 64'h1);

    // Reset while a response is presented
    fill(23'h100, 23'h108, 23'h2000, 10'h3FF);
    lookup(23'h101);
    i_rst_n = 1'b0;
    #1;
    check("midrst_outs", 64'({o_rspValid, o_hit, o_fault, o_miss}), 64'd0);
    check("midrst_ppn",  64'(o_PPN), 64'd0);
    check("midrst_cnts", 64'({o_hitCnt, o_missCnt}), 64'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    lookup(23'h101);
    check("midrst_entries_cleared", 64'(o_miss), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [22:0] s, e;
      s = 23'('h100 + ($urandom % 8) * 'h10);
      e = 23'(int'(s) + int'($urandom % 28) - 4);
      step(($urandom % 4) != 0, 23'('hF8 + $urandom % 144),
           ($urandom % 3) == 0, s, e, 23'($urandom),
           (($urandom % 4) == 0) ? 10'($urandom) : 10'h3FF,
           ($urandom % 50) == 0);
    end

    // Hit counter saturation
    fill(23'hA000, 23'hA100, 23'h1234, 10'h3FF);
    for (int n = 0; n < 65536 + 3; n++) lookup(23'(int'('hA000) + int'($urandom % 256)));
    check("hitcnt_sat", 64'(o_hitCnt), 64'hFFFF);

    repeat (2) @(negedge i_clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
